// File: rtl/fifo_rd_streamer.sv
// Drains a synchronous FIFO read port into a valid/ready stream via a small circular skid buffer.
// Marks every PKT_LEN-th beat as last and keeps a wrapping 32-bit count of transferred beats.
module fifo_rd_streamer #(
  parameter int DATA_W     = 32,
  parameter int SKID_DEPTH = 2,
  parameter int PKT_LEN    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              fifo_re_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic [31:0]       beat_cnt_o
);

  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam int OCC_W = $clog2(SKID_DEPTH + 1);
  localparam int PKT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SKID_DEPTH - 1);
  localparam logic [OCC_W:0]   DEPTH_X  = (OCC_W + 1)'(SKID_DEPTH);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(SKID_DEPTH);
  localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PKT_LEN - 1);

  logic [DATA_W-1:0] buf_q [SKID_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              inflight_q;
  logic [PKT_W-1:0]  pkt_idx_q, pkt_idx_d;
  logic [31:0]       beat_cnt_q, beat_cnt_d;
  logic              pop;
  logic [OCC_W:0]    occ_after;

  assign m_valid_o  = (occ_q != '0);
  assign m_data_o   = buf_q[head_q];
  assign m_last_o   = m_valid_o & (pkt_idx_q == PKT_LAST);
  assign beat_cnt_o = beat_cnt_q;
  assign pop        = m_valid_o & m_ready_i;

  // Occupancy once the word in flight lands and this cycle's pop leaves; a new read must still fit.
  assign occ_after = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q} - {{OCC_W{1'b0}}, pop};
  assign fifo_re_o = !rst && !fifo_empty_i && (occ_after < DEPTH_X);

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    pkt_idx_d  = pkt_idx_q;
    occ_d      = occ_after[OCC_W-1:0];
    beat_cnt_d = beat_cnt_q + 32'(pop);
    if (inflight_q) begin
      tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d    = (head_q == PTR_LAST) ? '0 : head_q + PTR_W'(1);
      pkt_idx_d = (pkt_idx_q == PKT_LAST) ? '0 : pkt_idx_q + PKT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      pkt_idx_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      if (inflight_q) begin
        buf_q[tail_q] <= fifo_data_i;
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= fifo_re_o;
      pkt_idx_q  <= pkt_idx_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // A word landing in a full buffer would overwrite the head.
  full_no_inflight_a: assert property (@(posedge clk) disable iff (rst)
    !((occ_q == OCC_FULL) && inflight_q));

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Randomized bench: behavioural FIFO source, expected-word queue and independent stream monitor.
module tb_fifo_rd_streamer;

  localparam int PKT_LEN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty_i;
  logic [31:0] fifo_data_i = '0;
  logic        fifo_re_o;
  logic        m_valid_o;
  logic        m_ready_i = 1'b0;
  logic [31:0] m_data_o;
  logic        m_last_o;
  logic [31:0] beat_cnt_o;

  int checks = 0;
  int errors = 0;

  fifo_rd_streamer #(.DATA_W(32), .SKID_DEPTH(2), .PKT_LEN(PKT_LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_re_o    (fifo_re_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .m_last_o     (m_last_o),
    .beat_cnt_o   (beat_cnt_o)
  );

  always #5 clk = ~clk;

  // Upstream FIFO: words written by the stimulus, read data appears the cycle after re.
  logic [31:0] mem [0:2047];
  int unsigned wp = 0;
  int unsigned rp = 0;
  assign fifo_empty_i = (rp == wp);

  always @(posedge clk) begin
    if (fifo_re_o) begin
      fifo_data_i <= mem[rp];
      rp          <= rp + 1;
    end
  end

  logic [31:0] exp_q [$];
  logic [31:0] mdl_beats  = '0;
  logic [31:0] cnt_offset = '0;
  int          mdl_pkt    = 0;
  int          pops       = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[wp] = w;
    wp++;
    exp_q.push_back(w);
  endtask

  // Monitor: on reset drop everything the FIFO already gave away; otherwise score each pop.
  logic        hold_vld = 1'b0;
  logic [31:0] held_dat;
  logic        held_last;

  always @(negedge clk) begin
    if (rst) begin
      hold_vld  = 1'b0;
      mdl_pkt   = 0;
      mdl_beats = '0;
      while (exp_q.size() > int'(wp - rp)) void'(exp_q.pop_front());
    end else begin
      if (hold_vld) begin
        check("valid_held", {31'b0, m_valid_o}, 32'd1);
        check("data_stable", m_data_o, held_dat);
        check("last_stable", {31'b0, m_last_o}, {31'b0, held_last});
      end
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=0x%08h required=none", m_data_o);
        end else begin
          check("beat_data", m_data_o, exp_q.pop_front());
        end
        check("beat_last", {31'b0, m_last_o}, {31'b0, mdl_pkt == PKT_LEN - 1});
        check("beat_cnt_pre", beat_cnt_o, mdl_beats + cnt_offset);
        mdl_pkt   = (mdl_pkt + 1) % PKT_LEN;
        mdl_beats = mdl_beats + 1;
        pops++;
        hold_vld  = 1'b0;
      end else if (m_valid_o) begin
        hold_vld  = 1'b1;
        held_dat  = m_data_o;
        held_last = m_last_o;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input bit rand_rdy, input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid_o) && n < max_cyc) begin
      if (rand_rdy) m_ready_i = 1'($urandom_range(0, 1));
      else m_ready_i = 1'b1;
      step();
      n++;
    end
    m_ready_i = 1'b1;
    step();
    step();
    check({tag, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rp0;
    int pushed;
    int n;
    logic [31:0] next_word;

    // 1) reset and idle with an empty FIFO
    rst = 1'b1;
    m_ready_i = 1'b1;
    step();
    step();
    check("rst_data", m_data_o, 32'd0);
    check("rst_last", {31'b0, m_last_o}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_re", {31'b0, fifo_re_o}, 32'd0);
      check("idle_valid", {31'b0, m_valid_o}, 32'd0);
      check("idle_cnt", beat_cnt_o, 32'd0);
    end
    step();

    // 2) preloaded 0x10..0x17 must stream back to back
    for (int i = 0; i < 8; i++) push_word(32'h10 + i);
    n = 0;
    while (!m_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t2_first_valid", {31'b0, m_valid_o}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("t2_rate", {31'b0, m_valid_o}, 32'd1);
      @(negedge clk);
    end
    step();
    check("t2_cnt", beat_cnt_o, 32'd8);
    check("t2_empty", exp_q.size(), 32'd0);

    // 3) downstream stalled: only two reads may be outstanding
    m_ready_i = 1'b0;
    rp0 = rp;
    for (int i = 0; i < 8; i++) push_word(32'h10 + i);
    for (int i = 0; i < 5; i++) step();
    check("t3_reads", rp - rp0, 32'd2);
    check("t3_head", m_data_o, 32'h10);
    check("t3_valid", {31'b0, m_valid_o}, 32'd1);
    drain("t3", 1'b0, 100);
    check("t3_cnt", beat_cnt_o, 32'd16);

    // 4) random traffic on both sides
    pushed = 0;
    n = 0;
    while (pushed < 1000 && n < 20000) begin
      m_ready_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 60) begin
        push_word($urandom);
        pushed++;
      end
      step();
      n++;
    end
    drain("t4", 1'b1, 10000);
    check("t4_cnt", beat_cnt_o, 32'd1016);

    // 5) reset while streaming with a word in flight
    m_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) push_word(32'hA0 + i);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_valid", {31'b0, m_valid_o}, 32'd0);
    check("t5_last", {31'b0, m_last_o}, 32'd0);
    check("t5_cnt", beat_cnt_o, 32'd0);
    check("t5_data", m_data_o, 32'd0);
    next_word = mem[rp];
    n = 0;
    while (!m_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_resume", m_data_o, next_word);
    drain("t5", 1'b0, 100);

    // 6) beat counter wrap
    m_ready_i = 1'b0;
    step();
    force dut.beat_cnt_q = 32'hFFFF_FFFE;
    step();
    release dut.beat_cnt_q;
    step();
    cnt_offset = 32'hFFFF_FFFE - mdl_beats;
    check("t6_preset", beat_cnt_o, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) push_word(32'hC0 + i);
    drain("t6", 1'b0, 100);
    check("t6_wrap", beat_cnt_o, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
